// File: rtl/dds_multi_iq.sv
// Time-multiplexed quadrature DDS: NCH phase accumulators share one quarter-wave
// sine ROM round-robin and feed a 3-stage pipeline to a channel-tagged valid/ready stream.
module dds_multi_iq #(
    parameter  int PW  = 32,
    parameter  int DW  = 12,
    parameter  int AW  = 10,
    parameter  int NCH = 4,
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 sync,
    input  logic                 cfg_we,
    input  logic [CW-1:0]        cfg_ch,
    input  logic                 cfg_sel,
    input  logic [PW-1:0]        cfg_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CW-1:0]        out_ch,
    output logic signed [DW-1:0] out_sin,
    output logic signed [DW-1:0] out_cos
);
    localparam int            RN      = 2 ** AW;
    localparam int            AMP     = 2 ** (DW - 1) - 1;
    localparam real           PI      = 3.14159265358979323846;
    localparam logic [CW-1:0] LAST_CH = CW'(NCH - 1);

    // Quarter-wave table built at elaboration; the half-LSB offset makes the mirror exact.
    logic [DW-2:0] w_rom [RN];
    for (genvar gi = 0; gi < RN; gi++) begin : g_rom
        localparam real ANG = (real'(gi) + 0.5) * PI / (2.0 * real'(RN));
        localparam int  VAL = $rtoi($floor($sin(ANG) * real'(AMP) + 0.5));
        assign w_rom[gi] = VAL[DW-2:0];
    end

    logic [PW-1:0]        r_acc   [NCH];
    logic [PW-1:0]        r_freq  [NCH];
    logic [PW-1:0]        r_phase [NCH];
    logic [CW-1:0]        r_ch_idx;

    logic                 r_s0_valid;
    logic [CW-1:0]        r_s0_ch;
    logic [AW+1:0]        r_s0_ph;
    logic                 r_s1_valid;
    logic [CW-1:0]        r_s1_ch;
    logic [DW-2:0]        r_s1_sin_mag;
    logic [DW-2:0]        r_s1_cos_mag;
    logic                 r_s1_sin_neg;
    logic                 r_s1_cos_neg;
    logic                 r_out_valid;
    logic [CW-1:0]        r_out_ch;
    logic signed [DW-1:0] r_out_sin;
    logic signed [DW-1:0] r_out_cos;

    logic                 w_stall;
    logic                 w_advance;
    logic [1:0]           w_q_sin;
    logic [1:0]           w_q_cos;
    logic [AW-1:0]        w_a;
    logic [AW-1:0]        w_addr_sin;
    logic [AW-1:0]        w_addr_cos;
    logic signed [DW-1:0] w_sin_ext;
    logic signed [DW-1:0] w_cos_ext;

    assign w_stall   = r_out_valid & ~out_ready;
    assign w_advance = en & ~w_stall;

    // NOTE: the per-channel register files must read as zero after reset, so they are
    // reset element by element and cannot be mapped onto a reset-less RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) r_acc[c] <= '0;
            r_ch_idx <= '0;
        end else if (sync) begin
            for (int c = 0; c < NCH; c++) r_acc[c] <= '0;
            r_ch_idx <= '0;
        end else if (w_advance) begin
            r_acc[r_ch_idx] <= r_acc[r_ch_idx] + r_freq[r_ch_idx];
            r_ch_idx        <= (r_ch_idx == LAST_CH) ? '0 : r_ch_idx + 1'b1;
        end
    end

    // A channel index outside 0..NCH-1 matches no entry, so the write is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                r_freq[c]  <= '0;
                r_phase[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (cfg_we && cfg_ch == CW'(c)) begin
                    if (cfg_sel) r_phase[c] <= cfg_data;
                    else         r_freq[c]  <= cfg_data;
                end
            end
        end
    end

    always_comb begin
        w_q_sin    = r_s0_ph[AW+1 -: 2];
        w_q_cos    = w_q_sin + 2'd1;
        w_a        = r_s0_ph[AW-1:0];
        w_addr_sin = w_q_sin[0] ? ~w_a : w_a;
        w_addr_cos = w_q_cos[0] ? ~w_a : w_a;
    end

    assign w_sin_ext = {1'b0, r_s1_sin_mag};
    assign w_cos_ext = {1'b0, r_s1_cos_mag};

    // Only the top AW+2 phase bits ever reach the ROM, so only those are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s0_valid   <= 1'b0;
            r_s0_ch      <= '0;
            r_s0_ph      <= '0;
            r_s1_valid   <= 1'b0;
            r_s1_ch      <= '0;
            r_s1_sin_mag <= '0;
            r_s1_cos_mag <= '0;
            r_s1_sin_neg <= 1'b0;
            r_s1_cos_neg <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_ch     <= '0;
            r_out_sin    <= '0;
            r_out_cos    <= '0;
        end else if (sync) begin
            r_s0_valid  <= 1'b0;
            r_s1_valid  <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (!w_stall) begin
            r_s0_valid   <= en;
            r_s0_ch      <= r_ch_idx;
            r_s0_ph      <= (AW+2)'((r_acc[r_ch_idx] + r_phase[r_ch_idx]) >> (PW - AW - 2));
            r_s1_valid   <= r_s0_valid;
            r_s1_ch      <= r_s0_ch;
            r_s1_sin_mag <= w_rom[w_addr_sin];
            r_s1_cos_mag <= w_rom[w_addr_cos];
            r_s1_sin_neg <= w_q_sin[1];
            r_s1_cos_neg <= w_q_cos[1];
            r_out_valid  <= r_s1_valid;
            r_out_ch     <= r_s1_ch;
            r_out_sin    <= r_s1_sin_neg ? -w_sin_ext : w_sin_ext;
            r_out_cos    <= r_s1_cos_neg ? -w_cos_ext : w_cos_ext;
        end
    end

    assign out_valid = r_out_valid;
    assign out_ch    = r_out_ch;
    assign out_sin   = r_out_sin;
    assign out_cos   = r_out_cos;

endmodule

// File: tb/tb_dds_multi_iq.sv
// Self-checking bench for dds_multi_iq: per-cycle comparison against an ideal
// trigonometric model, a table of fixed phase vectors, and directed corner sequences.
module tb_dds_multi_iq;
    localparam int  PW  = 32;
    localparam int  DW  = 12;
    localparam int  AW  = 10;
    localparam int  NCH = 4;
    localparam int  CW  = 2;
    localparam real PI  = 3.14159265358979323846;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en;
    logic                 sync;
    logic                 cfg_we;
    logic [CW-1:0]        cfg_ch;
    logic                 cfg_sel;
    logic [PW-1:0]        cfg_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [CW-1:0]        out_ch;
    logic signed [DW-1:0] out_sin;
    logic signed [DW-1:0] out_cos;

    int n_vec = 0;
    int n_err = 0;

    dds_multi_iq #(.PW(PW), .DW(DW), .AW(AW), .NCH(NCH)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sync     (sync),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_sel  (cfg_sel),
        .cfg_data (cfg_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ch   (out_ch),
        .out_sin  (out_sin),
        .out_cos  (out_cos)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            v;
        int            ch;
        logic [PW-1:0] psum;
    } slot_t;

    typedef struct {
        logic [PW-1:0] phase;
        int            want_sin;
        int            want_cos;
    } vec_t;

    // Reference: ideal phase accumulation plus a 3-sample delay line; samples come from $sin/$cos.
    slot_t         m_pipe [3];
    logic [PW-1:0] m_acc   [NCH];
    logic [PW-1:0] m_freq  [NCH];
    logic [PW-1:0] m_phase [NCH];
    int            m_ch;

    vec_t vecs [7];
    int   t1_sin [4] = '{2, 2047, -2, -2047};
    int   t1_cos [4] = '{2047, -2, -2047, 2};
    int   lat, n0, nexp, seen;
    int   s_ch, s_sin, s_cos;

    task automatic check(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic int ideal(input logic [PW-1:0] psum, input bit want_cos);
        real th;
        real v;
        th = (real'(psum[PW-1 -: AW+2]) + 0.5) * 2.0 * PI / real'(2 ** (AW + 2));
        v  = (want_cos ? $cos(th) : $sin(th)) * real'(2 ** (DW - 1) - 1);
        return $rtoi($floor(v + 0.5));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_acc[i]   = '0;
            m_freq[i]  = '0;
            m_phase[i] = '0;
        end
        for (int s = 0; s < 3; s++) m_pipe[s] = '{1'b0, 0, '0};
        m_ch = 0;
    endtask

    task automatic model_step();
        bit stall;
        if (rst) begin
            model_reset();
            return;
        end
        stall = m_pipe[2].v && !out_ready;
        if (sync) begin
            for (int i = 0; i < NCH; i++) m_acc[i] = '0;
            for (int s = 0; s < 3; s++) m_pipe[s].v = 1'b0;
            m_ch = 0;
        end else if (!stall) begin
            m_pipe[2] = m_pipe[1];
            m_pipe[1] = m_pipe[0];
            m_pipe[0] = '{en, m_ch, m_acc[m_ch] + m_phase[m_ch]};
            if (en) begin
                m_acc[m_ch] = m_acc[m_ch] + m_freq[m_ch];
                m_ch        = (m_ch + 1) % NCH;
            end
        end
        if (cfg_we && int'(cfg_ch) < NCH) begin
            if (cfg_sel) m_phase[cfg_ch] = cfg_data;
            else         m_freq[cfg_ch]  = cfg_data;
        end
    endtask

    // One clock: model follows the edge, DUT is compared at the following falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("out_valid", int'(out_valid), int'(m_pipe[2].v));
        if (m_pipe[2].v) begin
            check("out_ch", int'(out_ch), m_pipe[2].ch);
            check("out_sin", int'(out_sin), ideal(m_pipe[2].psum, 1'b0));
            check("out_cos", int'(out_cos), ideal(m_pipe[2].psum, 1'b1));
        end
    endtask

    task automatic do_cfg(input int ch, input bit sel, input logic [PW-1:0] data);
        cfg_we   = 1'b1;
        cfg_ch   = CW'(ch);
        cfg_sel  = sel;
        cfg_data = data;
        cycle();
        cfg_we   = 1'b0;
    endtask

    task automatic observe_t1();
        check("ch_order", int'(out_ch), nexp % NCH);
        nexp++;
        if (out_ch == 0) begin
            check("t1_ch0_sin", int'(out_sin), t1_sin[n0 % 4]);
            check("t1_ch0_cos", int'(out_cos), t1_cos[n0 % 4]);
            n0++;
        end else if (out_ch == 1) begin
            check("t2_ch1_sin", int'(out_sin), 2047);
            check("t2_ch1_cos", int'(out_cos), -2);
        end else begin
            check("t2_chx_sin", int'(out_sin), 2);
            check("t2_chx_cos", int'(out_cos), 2047);
        end
    endtask

    initial begin
        vecs[0] = '{32'h0000_0000, 2, 2047};
        vecs[1] = '{32'h4000_0000, 2047, -2};
        vecs[2] = '{32'h8000_0000, -2, -2047};
        vecs[3] = '{32'hC000_0000, -2047, 2};
        vecs[4] = '{32'hFFFF_FFFF, -2, 2047};
        vecs[5] = '{32'h3FFF_FFFF, 2047, 2};
        vecs[6] = '{32'h2000_0000, 1449, 1446};

        rst = 1'b1; en = 1'b0; sync = 1'b0; cfg_we = 1'b0;
        cfg_ch = '0; cfg_sel = 1'b0; cfg_data = '0; out_ready = 1'b1;
        model_reset();
        @(negedge clk);
        repeat (2) cycle();
        check("rst_valid", int'(out_valid), 0);
        check("rst_ch", int'(out_ch), 0);
        check("rst_sin", int'(out_sin), 0);
        check("rst_cos", int'(out_cos), 0);
        rst = 1'b0;
        cycle();

        // Quarter-turn rotation on ch0, static quarter phase on ch1, ch2/ch3 idle.
        do_cfg(0, 1'b0, 32'h4000_0000);
        do_cfg(1, 1'b1, 32'h4000_0000);
        en  = 1'b1;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            cycle();
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        check("first_latency", lat, 3);
        n0 = 0; nexp = 0;
        for (int k = 0; k < 16; k++) begin
            if (out_valid) observe_t1();
            cycle();
        end

        // Back-pressure for 5 cycles: presented sample must hold, then flow resumes in order.
        out_ready = 1'b0;
        s_ch = int'(out_ch); s_sin = int'(out_sin); s_cos = int'(out_cos);
        repeat (5) begin
            cycle();
            check("stall_valid", int'(out_valid), 1);
            check("stall_ch", int'(out_ch), s_ch);
            check("stall_sin", int'(out_sin), s_sin);
            check("stall_cos", int'(out_cos), s_cos);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (out_valid) observe_t1();
            cycle();
        end

        // Sync with same-cycle freq write: restart at ch0, then reverse rotation.
        sync = 1'b1;
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_sel = 1'b0; cfg_data = 32'hFFFF_FFFF;
        cycle();
        sync = 1'b0; cfg_we = 1'b0;
        check("sync_valid_drop", int'(out_valid), 0);
        seen = 0;
        for (int k = 0; k < 8 && seen == 0; k++) begin
            cycle();
            if (out_valid) seen = 1;
        end
        check("sync_restart_seen", seen, 1);
        check("sync_first_ch", int'(out_ch), 0);
        check("sync_first_sin", int'(out_sin), 2);
        check("sync_first_cos", int'(out_cos), 2047);
        seen = 0;
        for (int k = 0; k < 8 && seen == 0; k++) begin
            cycle();
            if (out_valid && out_ch == 0) seen = 1;
        end
        check("rev_seen", seen, 1);
        check("rev_sin", int'(out_sin), -2);
        check("rev_cos", int'(out_cos), 2047);

        // Asynchronous reset between edges while streaming.
        #2 rst = 1'b1;
        #1;
        check("arst_valid", int'(out_valid), 0);
        check("arst_ch", int'(out_ch), 0);
        check("arst_sin", int'(out_sin), 0);
        check("arst_cos", int'(out_cos), 0);
        model_reset();
        cycle();
        cycle();
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 16; k++) begin
            cycle();
            if (out_valid) begin
                seen++;
                check("post_rst_sin", int'(out_sin), 2);
                check("post_rst_cos", int'(out_cos), 2047);
            end
        end
        check("post_rst_samples", int'(seen > 8), 1);

        // Table of fixed phase offsets on ch0 (freq 0), one sample each.
        en = 1'b0;
        for (int v = 0; v < 7; v++) begin
            sync = 1'b1;
            cfg_we = 1'b1; cfg_ch = 2'd0; cfg_sel = 1'b1; cfg_data = vecs[v].phase;
            cycle();
            sync = 1'b0; cfg_we = 1'b0;
            en = 1'b1;
            cycle();
            en = 1'b0;
            for (int k = 0; k < 8 && !out_valid; k++) cycle();
            check("tbl_valid", int'(out_valid), 1);
            check("tbl_ch", int'(out_ch), 0);
            check("tbl_sin", int'(out_sin), vecs[v].want_sin);
            check("tbl_cos", int'(out_cos), vecs[v].want_cos);
            cycle();
        end

        // Randomized traffic against the model.
        for (int c = 0; c < NCH; c++) begin
            do_cfg(c, 1'b0, $urandom);
            do_cfg(c, 1'b1, $urandom);
        end
        for (int k = 0; k < 800; k++) begin
            en        = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            sync      = ($urandom_range(0, 63) == 0);
            cfg_we    = ($urandom_range(0, 11) == 0);
            cfg_ch    = CW'($urandom_range(0, NCH - 1));
            cfg_sel   = 1'($urandom_range(0, 1));
            cfg_data  = $urandom;
            cycle();
        end
        en = 1'b0; sync = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
        repeat (4) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
